// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO frame slave.
//   state_t       : frame decoder states, in the order fields arrive on the wire
//   OP_READ/WRITE : OP field codes
//   TA_WRITE      : turnaround pattern the master must drive on writes
//   *_LEN         : field lengths in bits
package mdio_pkg;

    typedef enum logic [2:0] {
        PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int OP_LEN    = 2;
    localparam int PHYAD_LEN = 5;
    localparam int REGAD_LEN = 5;
    localparam int TA_LEN    = 2;
    localparam int DATA_LEN  = 16;

endpackage

// File: rtl/mdio_preamble_det.sv
// Preamble detector: counts consecutive ones, saturating at PRE_LEN.
//   clk, reset : system clock, async active-high reset
//   bit_vld    : bit strobe, already qualified by the caller to the PRE state
//   mdio_i     : serial data
//   clear      : forces the count to zero (held while a frame is in progress)
//   pre_ok     : a 0 bit now would be a legal start of frame
module mdio_preamble_det #(
    parameter int PRE_LEN      = 32,
    parameter int PRE_SUPPRESS = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_vld,
    input  logic mdio_i,
    input  logic clear,
    output logic pre_ok
);

    localparam int CW = $clog2(PRE_LEN + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (bit_vld) begin
            if (!mdio_i)
                count <= '0;
            else if (count != CW'(PRE_LEN))
                count <= count + CW'(1);
        end
    end

    assign pre_ok = (PRE_SUPPRESS != 0) || (count == CW'(PRE_LEN));

endmodule

// File: rtl/mdio_frame_slave.sv
// Clause 22 MDIO management slave (PHY side) serving NUM_PORTS consecutive
// PHY addresses starting at PHY_BASE.
//   clk, reset          : system clock, async active-high reset
//   bit_vld, mdio_i     : one strobe per MDC bit and the sampled data bit
//   mdio_o, mdio_oe     : read data toward the master and pad enable
//   port_idx, reg_addr  : decoded target of the last matching frame
//   wr_data, wr_stb     : write data and one-cycle write strobe
//   rd_stb, rd_data     : one-cycle read request, data valid by TA bit 2
//   frame_done          : pulse at the end of an accepted frame
//   frame_err           : pulse on an ST, OP or write TA violation
module mdio_frame_slave import mdio_pkg::*; #(
    parameter logic [4:0] PHY_BASE     = 5'd0,
    parameter int         NUM_PORTS    = 1,
    parameter int         PRE_LEN      = 32,
    parameter int         PRE_SUPPRESS = 0,
    parameter int         PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_vld,
    input  logic              mdio_i,
    output logic              mdio_o,
    output logic              mdio_oe,
    output logic [PORT_W-1:0] port_idx,
    output logic [4:0]        reg_addr,
    output logic [15:0]       wr_data,
    output logic              wr_stb,
    output logic              rd_stb,
    input  logic [15:0]       rd_data,
    output logic              frame_done,
    output logic              frame_err
);

    state_t      state, next_state;
    logic [3:0]  cnt;       // bit index within the current field
    logic [15:0] sh;        // write data in, read data out
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic        pre_ok;

    logic [1:0]  op_full;
    logic        op_ok, is_read, addr_match, ta_bad;
    logic [5:0]  phy_ext;

    logic ev_err, ev_match, ev_ta1, ev_ta2, ev_rshift, ev_rdone, ev_wdone;

    assign op_full    = {op[0], mdio_i};
    assign op_ok      = (op_full == OP_READ) || (op_full == OP_WRITE);
    assign is_read    = (op == OP_READ);
    assign phy_ext    = {1'b0, phy};
    assign addr_match = (phy_ext >= {1'b0, PHY_BASE}) &&
                        (phy_ext <  {1'b0, PHY_BASE} + 6'(NUM_PORTS));
    // cnt=0 expects TA_WRITE[1], cnt=1 expects TA_WRITE[0]
    assign ta_bad     = (mdio_i != TA_WRITE[~cnt[0]]);

    mdio_preamble_det #(
        .PRE_LEN      (PRE_LEN),
        .PRE_SUPPRESS (PRE_SUPPRESS)
    ) u_pre (
        .clk     (clk),
        .reset   (reset),
        .bit_vld (bit_vld && (state == PRE)),
        .mdio_i  (mdio_i),
        .clear   (state != PRE),
        .pre_ok  (pre_ok)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PRE;
        else       state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        if (bit_vld) begin
            case (state)
                PRE:   if (!mdio_i && pre_ok) next_state = ST;
                ST:    next_state = mdio_i ? OP : PRE;
                OP:    if (cnt == 4'(OP_LEN - 1))
                           next_state = op_ok ? PHYAD : PRE;
                PHYAD: if (cnt == 4'(PHYAD_LEN - 1)) next_state = REGAD;
                REGAD: if (cnt == 4'(REGAD_LEN - 1))
                           next_state = addr_match ? TA : PRE;
                TA:    if (!is_read && ta_bad)        next_state = PRE;
                       else if (cnt == 4'(TA_LEN - 1)) next_state = is_read ? RDATA : WDATA;
                WDATA: if (cnt == 4'(DATA_LEN - 1)) next_state = PRE;
                RDATA: if (cnt == 4'(DATA_LEN - 1)) next_state = PRE;
                default: next_state = PRE;
            endcase
        end
    end

    // per-strobe events that drive the registered outputs
    always_comb begin
        ev_err    = 1'b0;
        ev_match  = 1'b0;
        ev_ta1    = 1'b0;
        ev_ta2    = 1'b0;
        ev_rshift = 1'b0;
        ev_rdone  = 1'b0;
        ev_wdone  = 1'b0;
        if (bit_vld) begin
            case (state)
                ST:    ev_err   = !mdio_i;
                OP:    ev_err   = (cnt == 4'(OP_LEN - 1)) && !op_ok;
                REGAD: ev_match = (cnt == 4'(REGAD_LEN - 1)) && addr_match;
                TA: begin
                    ev_err = !is_read && ta_bad;
                    ev_ta1 = is_read && (cnt == 4'd0);
                    ev_ta2 = is_read && (cnt == 4'(TA_LEN - 1));
                end
                WDATA: ev_wdone = (cnt == 4'(DATA_LEN - 1));
                RDATA: begin
                    ev_rdone  = (cnt == 4'(DATA_LEN - 1));
                    ev_rshift = !ev_rdone;
                end
                default: ;
            endcase
        end
    end

    // datapath and registered outputs; pulses last exactly one clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            sh         <= '0;
            op         <= '0;
            phy        <= '0;
            regad      <= '0;
            mdio_o     <= 1'b0;
            mdio_oe    <= 1'b0;
            port_idx   <= '0;
            reg_addr   <= '0;
            wr_data    <= '0;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_stb     <= ev_wdone;
            rd_stb     <= ev_match && is_read;
            frame_done <= ev_wdone || ev_rdone;
            frame_err  <= ev_err;
            if (bit_vld) begin
                cnt <= (next_state != state) ? 4'd0 : cnt + 4'd1;
                if (state == OP)    op    <= op_full;
                if (state == PHYAD) phy   <= {phy[3:0], mdio_i};
                if (state == REGAD) regad <= {regad[3:0], mdio_i};
                if (state == WDATA) sh    <= {sh[14:0], mdio_i};
                if (ev_match) begin
                    port_idx <= PORT_W'(phy - PHY_BASE);
                    reg_addr <= {regad[3:0], mdio_i};
                end
                if (ev_wdone) wr_data <= {sh[14:0], mdio_i};
                if (ev_ta1) begin
                    mdio_oe <= 1'b1;
                    mdio_o  <= 1'b0;
                end
                // bit 15 goes straight out; the rest queue up MSB-first
                if (ev_ta2) begin
                    mdio_o <= rd_data[15];
                    sh     <= {rd_data[14:0], 1'b0};
                end
                if (ev_rshift) begin
                    mdio_o <= sh[15];
                    sh     <= {sh[14:0], 1'b0};
                end
                if (ev_rdone) begin
                    mdio_oe <= 1'b0;
                    mdio_o  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_frame_slave.sv
// Bench for mdio_frame_slave: directed frames plus random frames, checked
// against a frame-level model. u0 needs a full preamble, u1 accepts none.
module tb_mdio_frame_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdio_i;
    logic [1:0]  vld;
    logic [15:0] rd_data;

    logic        mdio_o[2], mdio_oe[2], wr_stb[2], rd_stb[2];
    logic        frame_done[2], frame_err[2];
    logic [0:0]  port_idx[2];
    logic [4:0]  reg_addr[2];
    logic [15:0] wr_data[2];

    always #5 clk = ~clk;

    mdio_frame_slave #(.PHY_BASE(5'd4), .NUM_PORTS(2), .PRE_LEN(32), .PRE_SUPPRESS(0)) u0 (
        .clk(clk), .reset(reset), .bit_vld(vld[0]), .mdio_i(mdio_i),
        .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .port_idx(port_idx[0]),
        .reg_addr(reg_addr[0]), .wr_data(wr_data[0]), .wr_stb(wr_stb[0]),
        .rd_stb(rd_stb[0]), .rd_data(rd_data), .frame_done(frame_done[0]),
        .frame_err(frame_err[0]));

    mdio_frame_slave #(.PHY_BASE(5'd4), .NUM_PORTS(2), .PRE_LEN(32), .PRE_SUPPRESS(1)) u1 (
        .clk(clk), .reset(reset), .bit_vld(vld[1]), .mdio_i(mdio_i),
        .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .port_idx(port_idx[1]),
        .reg_addr(reg_addr[1]), .wr_data(wr_data[1]), .wr_stb(wr_stb[1]),
        .rd_stb(rd_stb[1]), .rd_data(rd_data), .frame_done(frame_done[1]),
        .frame_err(frame_err[1]));

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int n_wr[2], n_rd[2], n_done[2], n_err[2], n_multi[2];

    initial for (int k = 0; k < 2; k++) begin
        n_wr[k] = 0; n_rd[k] = 0; n_done[k] = 0; n_err[k] = 0; n_multi[k] = 0;
    end

    // pulse monitor: every registered pulse is high across exactly one negedge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            n_wr[k]   += int'(wr_stb[k]);
            n_rd[k]   += int'(rd_stb[k]);
            n_done[k] += int'(frame_done[k]);
            n_err[k]  += int'(frame_err[k]);
            if (int'(wr_stb[k]) + int'(rd_stb[k]) + int'(frame_err[k]) > 1) n_multi[k]++;
        end
    end

    typedef struct {
        int         pre;
        logic       st;
        logic [1:0] op;
        logic [4:0] phy;
        logic [4:0] rg;
        logic [1:0] ta;
        logic [15:0] data;
    } frame_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one bit: strobe on the next posedge, return at the following negedge
    task automatic send_bit(input logic b);
        @(negedge clk);
        mdio_i   = b;
        vld[sel] = 1'b1;
        @(negedge clk);
        vld = 2'b00;
    endtask

    // Sends one frame to DUT 'sel' and checks it against the frame-level rules.
    // abort_at>0 asserts reset after that many read data bits.
    task automatic run_frame(input string tag, input frame_t f, input bit lead0, input int abort_at);
        bit exp_wr = 0, exp_rd = 0, exp_err = 0;
        bit start;
        logic [17:0] oe_seq = '0, o_seq = '0;
        int s_wr, s_rd, s_done, s_err;
        start = (sel == 1) || (f.pre >= 32);
        if (start) begin
            if (!f.st)                                    exp_err = 1;
            else if (f.op != 2'b01 && f.op != 2'b10)      exp_err = 1;
            else if (f.phy >= 5'd4 && f.phy <= 5'd5) begin
                if (f.op == 2'b10)       exp_rd  = 1;
                else if (f.ta == 2'b10)  exp_wr  = 1;
                else                     exp_err = 1;
            end
        end
        s_wr = n_wr[sel]; s_rd = n_rd[sel]; s_done = n_done[sel]; s_err = n_err[sel];
        rd_data = f.data;
        if (lead0) send_bit(1'b0);
        for (int i = 0; i < f.pre; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(f.st);
        for (int i = 1; i >= 0; i--) send_bit(f.op[i]);
        for (int i = 4; i >= 0; i--) send_bit(f.phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(f.rg[i]);
        for (int i = 1; i >= 0; i--) begin
            send_bit(f.ta[i]);
            oe_seq[16+i] = mdio_oe[sel];
            o_seq[16+i]  = mdio_o[sel];
        end
        for (int k = 1; k <= 16; k++) begin
            send_bit(f.data[16-k]);
            oe_seq[16-k] = mdio_oe[sel];
            o_seq[16-k]  = mdio_o[sel];
            if (k == abort_at) begin
                chk({tag, " oe before reset"}, mdio_oe[sel], 1'b1);
                reset = 1'b1;
                #1;
                chk({tag, " oe on reset"}, mdio_oe[sel], 1'b0);
                chk({tag, " outputs on reset"},
                    {mdio_o[sel], wr_stb[sel], rd_stb[sel], frame_done[sel], frame_err[sel],
                     port_idx[sel], reg_addr[sel], wr_data[sel]}, '0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        repeat (2) @(negedge clk);
        chk({tag, " wr_stb"},     n_wr[sel]   - s_wr,   exp_wr);
        chk({tag, " rd_stb"},     n_rd[sel]   - s_rd,   exp_rd);
        chk({tag, " frame_done"}, n_done[sel] - s_done, exp_wr | exp_rd);
        chk({tag, " frame_err"},  n_err[sel]  - s_err,  exp_err);
        if (exp_wr || exp_rd) begin
            chk({tag, " port_idx"}, port_idx[sel], f.phy - 5'd4);
            chk({tag, " reg_addr"}, reg_addr[sel], f.rg);
        end
        if (exp_wr) chk({tag, " wr_data"}, wr_data[sel], f.data);
        // samples after TA1, TA2, D1..D16: drive is 0, rd_data[15:0], then released
        chk({tag, " oe seq"}, oe_seq, exp_rd ? 18'h3fffe : 18'h0);
        chk({tag, " o seq"},  o_seq,  exp_rd ? {1'b0, f.data, 1'b0} : 18'h0);
    endtask

    function automatic frame_t mk(int pre, logic [1:0] op, logic [4:0] phy, logic [4:0] rg,
                                  logic [1:0] ta, logic [15:0] data);
        frame_t f;
        f.pre = pre; f.st = 1'b1; f.op = op; f.phy = phy; f.rg = rg; f.ta = ta; f.data = data;
        return f;
    endfunction

    initial begin
        frame_t f;
        int r;
        reset   = 1'b1;
        vld     = 2'b00;
        mdio_i  = 1'b1;
        rd_data = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset state u%0d", k),
                {mdio_o[k], mdio_oe[k], wr_stb[k], rd_stb[k], frame_done[k], frame_err[k],
                 port_idx[k], reg_addr[k], wr_data[k]}, '0);
        reset = 1'b0;
        @(negedge clk);

        sel = 0;
        run_frame("write p5",   mk(32, 2'b01, 5'd5, 5'h03, 2'b10, 16'hA5C3), 1, 0);
        run_frame("read p4",    mk(32, 2'b10, 5'd4, 5'h1F, 2'b11, 16'h8001), 1, 0);
        run_frame("read p7",    mk(32, 2'b10, 5'd7, 5'h02, 2'b11, 16'h1234), 1, 0);
        run_frame("after p7",   mk(32, 2'b01, 5'd4, 5'h07, 2'b10, 16'h0F0F), 1, 0);
        run_frame("op 11",      mk(32, 2'b11, 5'd4, 5'h01, 2'b10, 16'h5555), 1, 0);
        run_frame("ta 11",      mk(32, 2'b01, 5'd5, 5'h01, 2'b11, 16'hAAAA), 1, 0);
        f = mk(32, 2'b01, 5'd4, 5'h09, 2'b10, 16'h3C3C);
        f.st = 1'b0;
        run_frame("st 0",       f, 1, 0);
        run_frame("pre 31",     mk(31, 2'b01, 5'd4, 5'h04, 2'b10, 16'h7777), 1, 0);
        run_frame("after pre31", mk(32, 2'b10, 5'd5, 5'h10, 2'b10, 16'hFEDC), 1, 0);

        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 9));
            f = mk(int'($urandom_range(32, 38)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                   5'($urandom_range(3, 6)), 5'($urandom), 2'b10, 16'($urandom));
            if (r == 0) f.op = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            if (r == 1) f.st = 1'b0;
            if (r == 2) f.ta = 2'($urandom);
            run_frame($sformatf("rand%0d", i), f, 1, 0);
        end

        sel = 1;
        run_frame("nopre w1", mk(0, 2'b01, 5'd4, 5'h05, 2'b10, 16'h1357), 0, 0);
        run_frame("nopre w2", mk(0, 2'b01, 5'd5, 5'h06, 2'b10, 16'h2468), 0, 0);
        run_frame("nopre rd", mk(0, 2'b10, 5'd5, 5'h0A, 2'b10, 16'hC001), 0, 0);

        sel = 0;
        run_frame("abort rd",  mk(32, 2'b10, 5'd4, 5'h11, 2'b11, 16'hB00B), 1, 8);
        run_frame("post rst",  mk(32, 2'b01, 5'd5, 5'h12, 2'b10, 16'h6DB6), 1, 0);

        chk("exclusive pulses u0", n_multi[0], 0);
        chk("exclusive pulses u1", n_multi[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_frame_slave.md
Name: mdio_frame_slave

Overview:
- Clause 22 MDIO management slave (PHY side) that decodes the full frame: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Answers a configurable range of PHY addresses, so one instance can serve several ports.
- Issues register-file write and read strobes and drives read data back onto the serial line.
- Sits between the MDIO pad and the per-port register files.

Parameters:
- PHY_BASE, 5'd0, lowest PHY address this block answers.
- NUM_PORTS, 1, number of consecutive PHY addresses served (1..32, PHY_BASE+NUM_PORTS ≤ 32).
- PRE_LEN, 32, consecutive preamble ones required before ST.
- PRE_SUPPRESS, 0, 1 = frames with no preamble are accepted.
- PORT_W, $clog2(NUM_PORTS) min 1, width of port_idx.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- bit_vld  in  1  one-cycle strobe, one per MDC bit; ≥2 clk between strobes
- mdio_i  in  1  serial data, sampled only when bit_vld=1
- mdio_o  out  1  serial data driven toward the master
- mdio_oe  out  1  pad output enable
- port_idx  out  PORT_W  PHYAD−PHY_BASE of the current frame
- reg_addr  out  5  REGAD of the current frame
- wr_data  out  16  write data
- wr_stb  out  1  one-cycle write strobe
- rd_stb  out  1  one-cycle read request
- rd_data  in  16  read data; must be valid by the second TA bit_vld
- frame_done  out  1  one-cycle pulse at the end of an accepted frame
- frame_err  out  1  one-cycle pulse on an ST, OP or TA violation

Behaviour:
- Reset (async): state=PRE, preamble count=0, every output 0.
- All state, counter and shift updates happen only on bit_vld cycles; otherwise everything holds.
- Serial fields are MSB first.
- PRE:
  - mdio_i=1 → increment the count, saturating at PRE_LEN.
  - mdio_i=0 with count≥PRE_LEN, or with PRE_SUPPRESS=1 → ST.
  - mdio_i=0 otherwise → count=0, stay in PRE.
- ST: mdio_i=1 → OP; mdio_i=0 → frame_err, PRE.
- OP: two bits. 10 = read, 01 = write. 00 or 11 → frame_err, PRE.
- PHYAD: five bits shifted in.
- REGAD: five bits shifted in. On the 5th bit the address is checked:
  - PHYAD outside [PHY_BASE, PHY_BASE+NUM_PORTS−1] → PRE silently: no strobes, no error, mdio_oe stays 0.
  - Match → port_idx and reg_addr update in that cycle and hold until the next match.
  - Match on a read → rd_stb pulses the following clk cycle.
- TA, write: bits must be 1 then 0, otherwise frame_err and PRE.
- TA, read:
  - After the 1st TA bit_vld: mdio_oe=1, mdio_o=0.
  - On the 2nd TA bit_vld: capture rd_data into the 16-bit shift register and drive mdio_o=rd_data[15].
- WDATA: 16 bits shifted in. On the 16th:
  - wr_data updates.
  - wr_stb and frame_done pulse the following cycle.
  - State → PRE, count=0.
- RDATA: bits 14..0 are presented on the next 15 bit_vld strobes. On the 16th RDATA bit_vld:
  - mdio_oe=0, mdio_o=0.
  - frame_done pulses.
  - State → PRE, count=0.
- Outputs change only on bit_vld cycles and hold between strobes, which gives the master a full bit period to sample.
- mdio_oe is 1 only during the TA2 bit and the read data bits, never for writes or unmatched frames.
- Input sampled by the master while the slave drives is ignored; no collision detection.
- wr_stb, rd_stb and frame_err never assert in the same cycle.
- Reset mid-frame aborts immediately; mdio_oe drops asynchronously.
- Back-to-back frames: each next frame needs PRE_LEN ones, unless PRE_SUPPRESS=1 (a 0 right after the frame starts ST).

Decomposition:
- Package mdio_pkg:
  - state enum: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA
  - OP_READ=2'b10, OP_WRITE=2'b01, TA_WRITE=2'b10
  - field length constants 5/5/2/16
- Sub-module mdio_preamble_det:
  - saturating ones counter with the PRE_LEN/PRE_SUPPRESS rule
  - output pre_ok; inputs bit_vld, mdio_i, clear

Test Plan:
- PHY_BASE=4, NUM_PORTS=2; preamble 32×1, write PHYAD=5, REGAD=0x03, data 0xA5C3 → one wr_stb with port_idx=1, reg_addr=3, wr_data=0xA5C3; mdio_oe never 1.
- Read PHYAD=4, REGAD=0x1F, rd_data=0x8001 → one rd_stb; mdio_oe rises after TA bit 1; mdio_o sequence is 0, then 1, 0×14, 1; oe drops on the 16th data strobe; frame_done=1.
- Read PHYAD=7 (unmatched) → no rd_stb, wr_stb or frame_err; mdio_oe stays 0; the next valid frame is accepted.
- OP=11, then a separate write with TA=11 → two frame_err pulses, no strobes, state back to PRE.
- PRE_LEN=32: only 31 ones before ST → frame ignored. PRE_SUPPRESS=1: back-to-back writes with no preamble → both wr_stb pulses.
- Reset asserted at the 8th read data bit → mdio_oe=0 immediately, outputs 0; after release a complete write succeeds.
